core_inst_sequencer: RTL and testbench

Autonomous instruction sequencer for the systolic core. It generates the 34-bit `inst` word each cycle that a host would otherwise drive by hand. Per kernel position (kij) it runs these phases in order:
- weight xmem→L0
- PE weight load
- settle gap
- activation xmem→L0
- execute
- OFIFO drain into pmem

After all kij it runs the pmem→SFP accumulation pass. It sits between the top-level start/done handshake and `core.inst`.

---
 rtl/core_ctrl_pkg.sv | 30 +++
 rtl/acc_addr_gen.sv | 33 +++
 rtl/core_inst_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_core_inst_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared control definitions for the core instruction sequencer: FSM states,
// bit positions inside the 34-bit core instruction word, and the idle word.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, W_L0, W_LOAD, GAP, X_L0, EXEC, DRAIN, ACC, DONE
  } state_e;

  localparam int INST_W = 34;
  localparam int ADDR_W = 11;

  localparam int INST_ACC        = 33;
  localparam int INST_CEN_PMEM   = 32;
  localparam int INST_WEN_PMEM   = 31;
  localparam int INST_A_PMEM_LSB = 20;
  localparam int INST_CEN_XMEM   = 19;
  localparam int INST_WEN_XMEM   = 18;
  localparam int INST_A_XMEM_LSB = 7;
  localparam int INST_OFIFO_RD   = 6;
  localparam int INST_IFIFO_WR   = 5;
  localparam int INST_IFIFO_RD   = 4;
  localparam int INST_L0_RD      = 3;
  localparam int INST_L0_WR      = 2;
  localparam int INST_EXECUTE    = 1;
  localparam int INST_LOAD       = 0;

  // Both memories deselected with write-enables inactive, every strobe low.
  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

endpackage

// File: rtl/acc_addr_gen.sv
// pmem address of the partial sum for output pixel o and kernel tap k:
// each kij owns a len_nij block, and tap k picks the input pixel shifted by
// (k/k_w, k%k_w) from the output pixel's (row, col).
module acc_addr_gen
  import core_ctrl_pkg::*;
#(
  parameter int IN_W    = 6,
  parameter int K_W     = 3,
  parameter int OUT_W   = 4,
  parameter int O_W     = 4,
  parameter int K_IDX_W = 4
) (
  input  logic [O_W-1:0]     o,
  input  logic [K_IDX_W-1:0] k,
  output logic [ADDR_W-1:0]  addr
);

  localparam int LEN_NIJ = IN_W * IN_W;

  logic [ADDR_W-1:0] o_x, k_x, orow, ocol, krow, kcol;

  // Pure arithmetic on constant divisors, evaluated at address width.
  always_comb begin
    o_x  = ADDR_W'(o);
    k_x  = ADDR_W'(k);
    orow = o_x / ADDR_W'(OUT_W);
    ocol = o_x % ADDR_W'(OUT_W);
    krow = k_x / ADDR_W'(K_W);
    kcol = k_x % ADDR_W'(K_W);
    addr = k_x * ADDR_W'(LEN_NIJ) + (orow + krow) * ADDR_W'(IN_W) + ocol + kcol;
  end

endmodule

// File: rtl/core_inst_sequencer.sv
// Autonomous instruction sequencer: walks every kernel position through
// weight load, activation load, execute and OFIFO drain, then runs the pmem
// accumulation pass, emitting one registered core instruction per cycle.
// The PE row count does not change the sequence, so it is not a parameter.
module core_inst_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int COL        = 8,
  parameter int IN_W       = 6,
  parameter int K_W        = 3,
  parameter int OUT_W      = 4,
  parameter int W_BASE     = 1024,
  parameter int GAP_CYCLES = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              sfp_clr,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij
);

  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_KIJ  = K_W * K_W;
  localparam int LEN_ONIJ = OUT_W * OUT_W;
  localparam int CW       = $clog2(LEN_NIJ + COL + GAP_CYCLES + LEN_KIJ + 4);
  localparam int OW       = $clog2(LEN_ONIJ);
  localparam int KW       = $clog2(LEN_KIJ);

  localparam logic [CW-1:0] C_COL      = CW'(COL);
  localparam logic [CW-1:0] C_COL_LAST = CW'(COL - 1);
  localparam logic [CW-1:0] C_GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] C_NIJ      = CW'(LEN_NIJ);
  localparam logic [CW-1:0] C_NIJ_LAST = CW'(LEN_NIJ - 1);
  localparam logic [CW-1:0] C_KIJ      = CW'(LEN_KIJ);
  localparam logic [CW-1:0] C_KIJ_P1   = CW'(LEN_KIJ + 1);
  localparam logic [CW-1:0] C_ACC_OV   = CW'(LEN_KIJ + 3);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              pend_q, pend_d;
  logic [OW-1:0]     o_q, o_d;
  logic [3:0]        kij_q, kij_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              sfp_clr_q, sfp_clr_d, out_valid_q, out_valid_d;
  logic [INST_W-1:0] inst_q, inst_d;

  logic [CW-1:0]     xlen;
  logic [ADDR_W-1:0] xbase, acc_addr;
  logic [KW-1:0]     acc_k;
  logic              drain_rd;

  // Tap index for the pmem read issued in ACC step cnt (steps 1..len_kij).
  assign acc_k = KW'(cnt_q - CW'(1));

  acc_addr_gen #(
    .IN_W(IN_W), .K_W(K_W), .OUT_W(OUT_W), .O_W(OW), .K_IDX_W(KW)
  ) u_acc_addr (
    .o(o_q), .k(acc_k), .addr(acc_addr)
  );

  // Next-state and next-instruction decode; each state step becomes the
  // instruction presented in the following cycle. In DRAIN the read
  // decision uses ofifo_valid as sampled at the launching edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    pend_d      = 1'b0;
    o_d         = o_q;
    kij_d       = kij_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sfp_clr_d   = 1'b0;
    out_valid_d = 1'b0;
    inst_d      = IDLE_INST;
    drain_rd    = 1'b0;
    xlen        = (state_q == W_L0) ? C_COL : C_NIJ;
    xbase       = (state_q == W_L0) ? ADDR_W'(W_BASE) : '0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = W_L0;
        cnt_d   = '0;
        kij_d   = '0;
        busy_d  = 1'b1;
      end
      W_L0, X_L0: begin
        // xmem read per step; the L0 write trails its read by one cycle.
        if (cnt_q < xlen) begin
          inst_d[INST_CEN_XMEM] = 1'b0;
          inst_d[INST_A_XMEM_LSB +: ADDR_W] = xbase + ADDR_W'(cnt_q);
        end
        if (cnt_q != '0) inst_d[INST_L0_WR] = 1'b1;
        if (cnt_q == xlen) begin
          cnt_d   = '0;
          state_d = (state_q == W_L0) ? W_LOAD : EXEC;
        end else cnt_d = cnt_q + CW'(1);
      end
      W_LOAD: begin
        inst_d[INST_L0_RD] = 1'b1;
        inst_d[INST_LOAD]  = 1'b1;
        if (cnt_q == C_COL_LAST) begin cnt_d = '0; state_d = GAP; end
        else cnt_d = cnt_q + CW'(1);
      end
      GAP: begin
        if (cnt_q == C_GAP_LAST) begin cnt_d = '0; state_d = X_L0; end
        else cnt_d = cnt_q + CW'(1);
      end
      EXEC: begin
        inst_d[INST_L0_RD]   = 1'b1;
        inst_d[INST_EXECUTE] = 1'b1;
        if (cnt_q == C_NIJ_LAST) begin cnt_d = '0; wcnt_d = '0; state_d = DRAIN; end
        else cnt_d = cnt_q + CW'(1);
      end
      DRAIN: begin
        // cnt counts OFIFO reads, wcnt counts the pmem writes trailing them.
        drain_rd = ofifo_valid && (cnt_q < C_NIJ);
        inst_d[INST_OFIFO_RD] = drain_rd;
        pend_d = drain_rd;
        if (drain_rd) cnt_d = cnt_q + CW'(1);
        if (pend_q) begin
          inst_d[INST_CEN_PMEM] = 1'b0;
          inst_d[INST_WEN_PMEM] = 1'b0;
          inst_d[INST_A_PMEM_LSB +: ADDR_W] =
            ADDR_W'(kij_q) * ADDR_W'(LEN_NIJ) + ADDR_W'(wcnt_q);
          wcnt_d = wcnt_q + CW'(1);
          if (wcnt_q == C_NIJ_LAST) begin
            cnt_d = '0;
            if (kij_q == 4'(LEN_KIJ - 1)) begin
              o_d     = '0;
              state_d = ACC;
            end else begin
              kij_d   = kij_q + 4'd1;
              state_d = W_L0;
            end
          end
        end
      end
      ACC: begin
        // Per pixel: clear, len_kij reads, acc trailing by one, idle, valid.
        sfp_clr_d = (cnt_q == '0);
        if (cnt_q >= CW'(1) && cnt_q <= C_KIJ) begin
          inst_d[INST_CEN_PMEM] = 1'b0;
          inst_d[INST_A_PMEM_LSB +: ADDR_W] = acc_addr;
        end
        if (cnt_q >= CW'(2) && cnt_q <= C_KIJ_P1) inst_d[INST_ACC] = 1'b1;
        if (cnt_q == C_ACC_OV) begin
          out_valid_d = 1'b1;
          cnt_d       = '0;
          if (o_q == OW'(LEN_ONIJ - 1)) state_d = DONE;
          else o_d = o_q + OW'(1);
        end else cnt_d = cnt_q + CW'(1);
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any run with no resume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      pend_q      <= 1'b0;
      o_q         <= '0;
      kij_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sfp_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      inst_q      <= IDLE_INST;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      pend_q      <= pend_d;
      o_q         <= o_d;
      kij_q       <= kij_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sfp_clr_q   <= sfp_clr_d;
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
    end
  end

  assign inst      = inst_q;
  assign sfp_clr   = sfp_clr_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign kij       = kij_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Bench for core_inst_sequencer: a phase-by-phase behavioural model predicts
// every output each cycle; observed pmem traffic is also pinned to literals.
module tb_core_inst_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [33:0] inst;
  logic        sfp_clr, out_valid, busy, done;
  logic [3:0]  kij;

  core_inst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .sfp_clr(sfp_clr), .out_valid(out_valid), .busy(busy),
    .done(done), .kij(kij)
  );

  always #5 clk = ~clk;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  int          n_chk = 0, n_fail = 0;
  logic [33:0] e_inst = IDLE_W;
  bit          e_clr = 0, e_ov = 0, e_done = 0, e_busy = 0;
  int          e_kij = 0;
  bit          aborted = 0;
  bit          vmode = 0;
  int          wr_q[$], rd_q[$];
  int          ov_cnt = 0, done_cnt = 0, drain_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- instruction field helpers ----------------
  function automatic logic [33:0] xrd(input logic [33:0] w, input int a);
    logic [33:0] r;
    r = w; r[19] = 1'b0; r[17:7] = a[10:0];
    return r;
  endfunction

  function automatic logic [33:0] prd(input logic [33:0] w, input int a);
    logic [33:0] r;
    r = w; r[32] = 1'b0; r[30:20] = a[10:0];
    return r;
  endfunction

  function automatic logic [33:0] pwr(input logic [33:0] w, input int a);
    logic [33:0] r;
    r = w; r[32] = 1'b0; r[31] = 1'b0; r[30:20] = a[10:0];
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  task automatic put(input logic [33:0] w, input bit clr, input bit ov,
                     input bit dn, input bit bz, input int kj);
    e_inst = w; e_clr = clr; e_ov = ov; e_done = dn; e_busy = bz; e_kij = kj;
  endtask

  // Advance to the next edge; a low reset there aborts the current run.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      aborted = 1;
      put(IDLE_W, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic run_model();
    logic [33:0] w;
    int reads, writes, nk, o, k;
    bit pend, rd;
    for (int kj = 0; kj < 9; kj++) begin
      for (int c = 0; c <= 8; c++) begin
        tick(); if (aborted) return;
        w = IDLE_W; if (c < 8) w = xrd(w, 1024 + c); if (c > 0) w[2] = 1'b1;
        put(w, 0, 0, 0, 1, kj);
      end
      for (int c = 0; c < 8; c++) begin
        tick(); if (aborted) return;
        w = IDLE_W; w[3] = 1'b1; w[0] = 1'b1;
        put(w, 0, 0, 0, 1, kj);
      end
      for (int c = 0; c < 10; c++) begin
        tick(); if (aborted) return;
        put(IDLE_W, 0, 0, 0, 1, kj);
      end
      for (int c = 0; c <= 36; c++) begin
        tick(); if (aborted) return;
        w = IDLE_W; if (c < 36) w = xrd(w, c); if (c > 0) w[2] = 1'b1;
        put(w, 0, 0, 0, 1, kj);
      end
      for (int c = 0; c < 36; c++) begin
        tick(); if (aborted) return;
        w = IDLE_W; w[3] = 1'b1; w[1] = 1'b1;
        put(w, 0, 0, 0, 1, kj);
      end
      reads = 0; writes = 0; pend = 0;
      while (writes < 36) begin
        tick(); if (aborted) return;
        w = IDLE_W; nk = kj;
        rd = (ofifo_valid === 1'b1) && (reads < 36);
        if (rd) w[6] = 1'b1;
        if (pend) begin
          w = pwr(w, kj * 36 + writes);
          writes++;
          if (writes == 36 && kj < 8) nk = kj + 1;
        end
        pend = rd;
        if (rd) reads++;
        put(w, 0, 0, 0, 1, nk);
      end
    end
    for (o = 0; o < 16; o++) begin
      for (int p = 0; p <= 12; p++) begin
        tick(); if (aborted) return;
        w = IDLE_W;
        if (p >= 1 && p <= 9) begin
          k = p - 1;
          w = prd(w, k * 36 + (o / 4 + k / 3) * 6 + (o % 4) + (k % 3));
        end
        if (p >= 2 && p <= 10) w[33] = 1'b1;
        put(w, p == 0, p == 12, 0, 1, 8);
      end
    end
    tick(); if (aborted) return;
    put(IDLE_W, 0, 0, 1, 0, 8);
  endtask

  initial begin
    forever begin
      tick();
      if (aborted) begin
        aborted = 0;
      end else if (start === 1'b1) begin
        put(IDLE_W, 0, 0, 0, 1, 0);
        run_model();
        aborted = 0;
      end else begin
        put(IDLE_W, 0, 0, 0, 0, e_kij);
      end
    end
  end

  // ---------------- per-cycle compare + traffic log ----------------
  always @(negedge clk) begin
    logic [41:0] act, expv;
    int a;
    act = {inst, sfp_clr, out_valid, busy, done, kij};
    if (!reset) expv = {IDLE_W, 4'b0000, 4'd0};
    else        expv = {e_inst, e_clr, e_ov, e_busy, e_done, 4'(e_kij)};
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL cycle_outputs t=%0t (got/expected) inst=%h/%h clr=%b/%b ov=%b/%b busy=%b/%b done=%b/%b kij=%0d/%0d",
                 $time, inst, expv[41:8], sfp_clr, expv[7], out_valid, expv[6],
                 busy, expv[5], done, expv[4], kij, expv[3:0]);
    end
    if (reset === 1'b1) begin
      a = int'(inst[30:20]);
      if (inst[32] === 1'b0 && inst[31] === 1'b0) begin
        wr_q.push_back(a);
        if (a % 36 == 35) drain_cnt++;
      end
      if (inst[32] === 1'b0 && inst[31] === 1'b1) rd_q.push_back(a);
      if (out_valid === 1'b1) ov_cnt++;
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ofifo_valid = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (vmode == 0) ofifo_valid = ~ofifo_valid;
      else            ofifo_valid = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic clear_log();
    wr_q.delete(); rd_q.delete();
    ov_cnt = 0; done_cnt = 0; drain_cnt = 0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    chk({nm, "_done_seen"}, longint'(seen), 1);
    chk({nm, "_busy_at_done"}, longint'(busy), 0);
    @(negedge clk); #1;
    chk({nm, "_done_one_cycle"}, longint'(done), 0);
  endtask

  int acc0[9] = '{0, 37, 74, 114, 151, 188, 228, 265, 302};
  bit found;

  initial begin
    reset = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    chk("reset_inst", longint'(inst), longint'(IDLE_W));
    chk("reset_busy", longint'(busy), 0);
    chk("reset_kij", longint'(kij), 0);
    @(posedge clk); #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    clear_log();

    // run 1: toggling ofifo_valid, plus a stray start mid-run
    pulse_start();
    repeat (50) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done("run1");
    chk("run1_pmem_writes", wr_q.size(), 324);
    chk("run1_drain_phases", drain_cnt, 9);
    chk("run1_out_valid", ov_cnt, 16);
    chk("run1_done_pulses", done_cnt, 1);
    chk("run1_pmem_reads", rd_q.size(), 144);
    if (wr_q.size() >= 144) begin
      chk("wr_kij0_first", wr_q[0], 0);
      chk("wr_kij0_last", wr_q[35], 35);
      chk("wr_kij3_first", wr_q[108], 108);
      chk("wr_kij3_last", wr_q[143], 143);
    end
    if (rd_q.size() >= 54) begin
      for (int i = 0; i < 9; i++) chk($sformatf("acc_o0_k%0d", i), rd_q[i], acc0[i]);
      chk("acc_o5_first", rd_q[45], 7);
      chk("acc_o5_last", rd_q[53], 309);
    end

    // run 2: random ofifo_valid, reset during EXEC of kij=4
    vmode = 1;
    repeat (3) @(posedge clk);
    pulse_start();
    found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (kij == 4'd4 && inst[1] === 1'b1 && busy === 1'b1) found = 1;
    end
    chk("reach_kij4_exec", longint'(found), 1);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("abort_inst", longint'(inst), longint'(IDLE_W));
    chk("abort_kij", longint'(kij), 0);
    chk("abort_busy", longint'(busy), 0);
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    clear_log();

    // run 3: restart after abort, random ofifo_valid
    pulse_start();
    wait_done("run3");
    chk("run3_pmem_writes", wr_q.size(), 324);
    chk("run3_out_valid", ov_cnt, 16);
    chk("run3_done_pulses", done_cnt, 1);
    if (wr_q.size() > 0) chk("run3_first_write", wr_q[0], 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
